// File: rtl/decoder3_8.sv
// Enable-gated one-hot decoder, leaf of the register-file write-select tree.
// IN_W=2 gives the 2-to-4 function, IN_W=3 the 3-to-8; REG_OUT adds one output stage.
module decoder3_8 #(
  parameter int IN_W    = 3,
  parameter bit REG_OUT = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_W-1:0]      in,
  input  logic                 en,
  output logic [2**IN_W-1:0]   out
);

  localparam int OUT_W = 2**IN_W;

  if (IN_W < 1 || IN_W > 5) begin : g_bad_width
    $error("decoder3_8: IN_W must be in 1..5");
  end

  logic [OUT_W-1:0] dec;

  // Every value of in maps to a valid output bit, so no range guard is needed.
  always_comb begin
    dec = '0;
    if (en) dec[in] = 1'b1;
  end

  if (REG_OUT) begin : g_reg
    logic [OUT_W-1:0] out_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) out_q <= '0;
      else       out_q <= dec;
    end

    assign out = out_q;
  end else begin : g_comb
    // clk and reset are deliberately ignored in the combinational build.
    logic unused_clk_reset;
    assign unused_clk_reset = clk | reset;
    assign out = dec;
  end

endmodule

// File: tb/tb_decoder3_8.sv
// Self-checking bench for decoder3_8: combinational 2/3-bit builds, registered build,
// and the 5-to-32 write-select tree, with a queue scoreboard of expected outputs.
module tb_decoder3_8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  // 3-to-8 combinational
  logic [2:0] c3_in = '0;
  logic       c3_en = 1'b0;
  logic [7:0] c3_out;
  decoder3_8 #(.IN_W(3), .REG_OUT(1'b0)) u_c3 (
    .clk(clk), .reset(reset), .in(c3_in), .en(c3_en), .out(c3_out));

  // 2-to-4 combinational
  logic [1:0] c2_in = '0;
  logic       c2_en = 1'b0;
  logic [3:0] c2_out;
  decoder3_8 #(.IN_W(2), .REG_OUT(1'b0)) u_c2 (
    .clk(clk), .reset(reset), .in(c2_in), .en(c2_en), .out(c2_out));

  // 3-to-8 registered
  logic [2:0] r3_in = '0;
  logic       r3_en = 1'b0;
  logic [7:0] r3_out;
  decoder3_8 #(.IN_W(3), .REG_OUT(1'b1)) u_r3 (
    .clk(clk), .reset(reset), .in(r3_in), .en(r3_en), .out(r3_out));

  // 5-to-32 tree
  logic [4:0]  addr = '0;
  logic        reg_write = 1'b0;
  logic [3:0]  t_sel;
  logic [31:0] out32;
  decoder3_8 #(.IN_W(2), .REG_OUT(1'b0)) u_t2 (
    .clk(clk), .reset(reset), .in(addr[4:3]), .en(reg_write), .out(t_sel));
  for (genvar j = 0; j < 4; j++) begin : g_leaf
    decoder3_8 #(.IN_W(3), .REG_OUT(1'b0)) u_leaf (
      .clk(clk), .reset(reset), .in(addr[2:0]), .en(t_sel[j]), .out(out32[8*j +: 8]));
  end

  // glitch monitor for the enable-toggle scenario
  logic mon_on = 1'b0;
  logic glitch_seen = 1'b0;
  always @(c3_out) begin
    if (mon_on && c3_out !== 8'h00 && c3_out !== 8'h40) glitch_seen = 1'b1;
  end

  function automatic logic [31:0] model(input int unsigned sel, input logic e);
    logic [31:0] one;
    one = 32'd1;
    return e ? (one << sel) : 32'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    r3_in = 3'd7;
    r3_en = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (r3_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", r3_out, 8'h00);
    end
    // combinational build ignores reset
    c3_in = 3'd2;
    c3_en = 1'b1;
    #1;
    n_checks++;
    if (c3_out !== 8'h04) begin
      n_fail++;
      $display("FAIL comb_during_reset: got %h expected %h", c3_out, 8'h04);
    end
  endtask

  task automatic test_sweep3();
    for (int i = 0; i < 8; i++) begin
      c3_in = 3'(i);
      c3_en = 1'b1;
      exp_q.push_back(model(i, 1'b1));
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({24'd0, c3_out} !== exp_v) begin
        n_fail++;
        $display("FAIL sweep3 in=%0d: got %h expected %h", i, c3_out, exp_v[7:0]);
      end
      #9;
    end
  endtask

  task automatic test_enable_low2();
    for (int i = 0; i < 4; i++) begin
      c2_in = 2'(i);
      c2_en = 1'b0;
      exp_q.push_back(32'd0);
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({28'd0, c2_out} !== exp_v) begin
        n_fail++;
        $display("FAIL en_low2 in=%0d: got %h expected %h", i, c2_out, exp_v[3:0]);
      end
      #9;
    end
    c2_in = 2'd2;
    c2_en = 1'b1;
    exp_q.push_back(32'h4);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({28'd0, c2_out} !== exp_v) begin
      n_fail++;
      $display("FAIL en_raise2: got %h expected %h", c2_out, exp_v[3:0]);
    end
  endtask

  task automatic test_toggle();
    logic pattern [3];
    pattern[0] = 1'b1;
    pattern[1] = 1'b0;
    pattern[2] = 1'b1;
    c3_in = 3'd6;
    c3_en = 1'b0;
    #5;
    glitch_seen = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c3_en = pattern[i];
      exp_q.push_back(model(6, pattern[i]));
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({24'd0, c3_out} !== exp_v) begin
        n_fail++;
        $display("FAIL toggle step%0d: got %h expected %h", i, c3_out, exp_v[7:0]);
      end
      #9;
    end
    mon_on = 1'b0;
    n_checks++;
    if (glitch_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_glitch: got %b expected %b", glitch_seen, 1'b0);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (r3_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reg_reset: got %h expected %h", r3_out, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
    r3_in = 3'd3;
    r3_en = 1'b1;
    exp_q.push_back(model(3, 1'b1));
    #1;
    n_checks++;
    if (r3_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reg_before_edge: got %h expected %h", r3_out, 8'h00);
    end
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({24'd0, r3_out} !== exp_v) begin
      n_fail++;
      $display("FAIL reg_latency: got %h expected %h", r3_out, exp_v[7:0]);
    end
    // load another value, then kill it with a mid-cycle reset
    @(negedge clk);
    r3_in = 3'd5;
    @(posedge clk);
    #1;
    n_checks++;
    if (r3_out !== 8'h20) begin
      n_fail++;
      $display("FAIL reg_second: got %h expected %h", r3_out, 8'h20);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (r3_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reg_async_reset: got %h expected %h", r3_out, 8'h00);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (r3_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reg_reset_held: got %h expected %h", r3_out, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_tree();
    for (int w = 1; w >= 0; w--) begin
      for (int a = 0; a < 32; a++) begin
        addr = 5'(a);
        reg_write = w[0];
        exp_q.push_back(model(a, w[0]));
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (out32 !== exp_v) begin
          n_fail++;
          $display("FAIL tree we=%0d addr=%0d: got %h expected %h", w, a, out32, exp_v);
        end
        #4;
      end
    end
  endtask

  task automatic test_random();
    logic       en_r;
    logic [2:0] in_r;
    logic [7:0] obs;
    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      en_r = 1'($urandom_range(0, 1));
      in_r = 3'($urandom_range(0, 7));
      c3_en = en_r;
      c3_in = in_r;
      r3_en = en_r;
      r3_in = in_r;
      exp_q.push_back(model(in_r, en_r));
      exp_q.push_back(model(in_r, en_r));
      #1;
      exp_v = exp_q.pop_front();
      obs = c3_out;
      n_checks++;
      if ({24'd0, obs} !== exp_v || $countones(obs) != int'(en_r)) begin
        n_fail++;
        $display("FAIL rand_comb n=%0d: got %h expected %h", n, obs, exp_v[7:0]);
      end
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      obs = r3_out;
      n_checks++;
      if ({24'd0, obs} !== exp_v || $countones(obs) != int'(en_r)) begin
        n_fail++;
        $display("FAIL rand_reg n=%0d: got %h expected %h", n, obs, exp_v[7:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    reset = 1'b0;
    test_sweep3();
    test_enable_low2();
    test_toggle();
    test_registered();
    test_tree();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder3_8.md
# decoder3_8

Enable-gated one-hot decoder used as the leaf of the register-file write-select tree. One 2-to-4 instance (IN_W=2) gated by regWrite drives the enables of four 3-to-8 instances (IN_W=3); together they form the 5-to-32 write decoder. The IN_W=2 configuration is the decoder2_4 function; the default IN_W=3 configuration is the decoder3_8 function. An optional output register lets the tree be pipelined.

## Interface
Parameters:
- IN_W, default 3: select width; output width is 2**IN_W. Legal values are 1..5; 2 and 3 are the production configurations.
- REG_OUT, default 0: 0 makes the decode purely combinational; 1 adds one output register stage.

Ports:
- clk  input  1  clock; used only when REG_OUT=1.
- reset  input  1  asynchronous, active-high reset; clears the output register.
- in  input  IN_W  binary select.
- en  input  1  decode enable (regWrite, or the select line from the upstream decoder).
- out  output  2**IN_W  one-hot decode result, bit k asserted for in==k.

## Operation
- When en=1, out[in]=1 and every other bit of out is 0.
- When en=0, out is all zeros regardless of in.
- out is never multi-hot. It has exactly one bit set when en=1 and is zero when en=0.
- All values of in are legal. There is no out-of-range case, because 2**IN_W covers the full select space.
- REG_OUT=0:
  - out is a pure function of {en, in}.
  - clk and reset have no effect on out.
- REG_OUT=1:
  - The combinational decode result is captured on each rising clk edge and drives out.
  - reset=1 forces out to 0 immediately, independent of clk.
  - While reset stays high, out remains 0.
- Tree composition:
  - 2-to-4 decoder: in = wr_addr[4:3], en = regWrite.
  - 3-to-8 decoder j (j = 0..3): in = wr_addr[2:0], en = sel[j]; its output drives out32[8j+7:8j].
  - Result: out32[a] = regWrite & (wr_addr == a).
- X or Z on in or en is not propagated as a legal state. Benches must drive known values.

## Timing
- REG_OUT=0:
  - Zero-cycle latency; out settles combinationally after any change of in or en.
  - Reset value: not applicable, since out tracks the inputs even while reset=1.
- REG_OUT=1:
  - One-cycle latency: the out visible after edge n reflects the {en, in} sampled at edge n.
  - Reset value of out is all zeros. Assertion clears out asynchronously.
  - On deassertion, out first updates at the next rising clk edge.
  - If reset is asserted mid-stream, the in-flight decode is discarded and out reads 0 on the following cycle.
  - If reset and a clk edge coincide, reset wins.
- No handshake and no internal state beyond the optional output register.

## Test plan
- Full sweep, IN_W=3, REG_OUT=0, en=1: drive in=0..7, one value every 10 time units -> out equals 1<<in each time (in=0 -> 8'h01, in=5 -> 8'h20, in=7 -> 8'h80).
- Enable low, IN_W=2, REG_OUT=0: sweep in=0..3 with en=0 -> out=4'h0 throughout. Raise en with in=2 -> out=4'h4.
- Enable toggle at fixed select, IN_W=3: hold in=6 and toggle en 1/0/1 -> out = 8'h40 / 8'h00 / 8'h40, with no glitch to a different one-hot value.
- Registered latency and reset, IN_W=3, REG_OUT=1:
  - With reset=1, out=0.
  - Release reset, apply in=3, en=1 -> out=8'h08 after the next rising edge, and 0 before it.
  - Assert reset asynchronously mid-cycle -> out=0 immediately.
- 5-to-32 tree (one 2-to-4 plus four 3-to-8): sweep addr=0..31 with regWrite=1 -> out32 = 1<<addr. Repeat the sweep with regWrite=0 -> out32=0 for all 32 addresses.
- One-hot property check: for random {en, in} over 1000 cycles, assert $countones(out) == en in both REG_OUT modes; in REG_OUT=1 mode, compare against the inputs from the previous cycle.
